// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: FSM state
// encoding, select width and the default watchdog timeout.
package wb_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_GNT0 = 2'd1,
        ARB_GNT1 = 2'd2,
        ARB_TOUT = 2'd3
    } arb_state_t;

    localparam int WB_SEL_W           = 3;
    localparam int WB_DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/wb_arbiter_if.sv
// One Wishbone link. The master modport drives the cycle, the slave modport
// answers it; the arbiter takes two slave-side links and one master-side link.
interface wb_arbiter_if;
    import wb_arbiter_pkg::*;

    logic                cyc;
    logic                stb;
    logic                we;
    logic [WB_SEL_W-1:0] sel;
    logic [31:0]         adr;
    logic [31:0]         wdat;
    logic [31:0]         rdat;
    logic                ack;
    logic                err;

    modport master (
        output cyc, stb, we, sel, adr, wdat,
        input  rdat, ack, err
    );

    modport slave (
        input  cyc, stb, we, sel, adr, wdat,
        output rdat, ack, err
    );

endinterface

// File: rtl/wb_watchdog.sv
// Bus watchdog: counts strobed cycles without a slave response and flags
// expiry on the cycle the count reaches TIMEOUT-1, so the owner is
// terminated TIMEOUT cycles after its first unanswered strobe.
module wb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic clr_i,
    output logic expired_o
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

    logic [15:0] r_count;

    // Wait counter: clear has priority, otherwise count unanswered strobes.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_count <= '0;
        end else if (clr_i) begin
            r_count <= '0;
        end else if (en_i) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign expired_o = en_i && !clr_i && (r_count >= LIMIT);

endmodule

// File: rtl/wb_arbiter.sv
// Two-master Wishbone arbiter sharing one slave port between instruction
// fetch (m0) and the memory stage (m1). Grant is held for as long as the
// owner keeps cyc high; a watchdog ends cycles the slave never answers.
// Optional feature macro WB_ARBITER_RR_EN: round-robin tie-break instead of
// fixed priority for master 1.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int TIMEOUT = WB_DEFAULT_TIMEOUT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    wb_arbiter_if.slave  m0,
    wb_arbiter_if.slave  m1,
    wb_arbiter_if.master s,
    output logic [1:0]  grant_o
);

    arb_state_t r_state;
    arb_state_t w_next;
    logic       r_owner;
    logic       w_granted;
    logic       w_wdEn;
    logic       w_expired;

    assign w_granted = (r_state == ARB_GNT0) || (r_state == ARB_GNT1);
    assign w_wdEn    = w_granted && s.stb && !s.ack && !s.err;

    wb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .en_i      (w_wdEn),
        .clr_i     (!w_wdEn),
        .expired_o (w_expired)
    );

    // State register plus the owner of the most recent grant; the owner is
    // needed to route the timeout error and doubles as the round-robin memory.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ARB_IDLE;
            r_owner <= 1'b1;
        end else begin
            r_state <= w_next;
            if (r_state == ARB_IDLE && w_next == ARB_GNT0) begin
                r_owner <= 1'b0;
            end else if (r_state == ARB_IDLE && w_next == ARB_GNT1) begin
                r_owner <= 1'b1;
            end
        end
    end

    // Next-state logic: arbitrate in IDLE, hold while the owner keeps cyc,
    // and spend exactly one cycle in TOUT after the watchdog fires.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ARB_IDLE: begin
`ifdef WB_ARBITER_RR_EN
                if (m0.cyc && m1.cyc) begin
                    w_next = r_owner ? ARB_GNT0 : ARB_GNT1;
                end else if (m1.cyc) begin
                    w_next = ARB_GNT1;
                end else if (m0.cyc) begin
                    w_next = ARB_GNT0;
                end
`else
                if (m1.cyc) begin
                    w_next = ARB_GNT1;
                end else if (m0.cyc) begin
                    w_next = ARB_GNT0;
                end
`endif
            end
            ARB_GNT0: begin
                if (w_expired) begin
                    w_next = ARB_TOUT;
                end else if (!m0.cyc) begin
                    w_next = ARB_IDLE;
                end
            end
            ARB_GNT1: begin
                if (w_expired) begin
                    w_next = ARB_TOUT;
                end else if (!m1.cyc) begin
                    w_next = ARB_IDLE;
                end
            end
            ARB_TOUT: w_next = ARB_IDLE;
            default:  w_next = ARB_IDLE;
        endcase
    end

    // Bus mux: every output is gated by the state, so reset silences the bus
    // immediately and a non-owner always sees zeros.
    always_comb begin
        s.cyc   = 1'b0;
        s.stb   = 1'b0;
        s.we    = 1'b0;
        s.sel   = '0;
        s.adr   = '0;
        s.wdat  = '0;
        m0.rdat = '0;
        m0.ack  = 1'b0;
        m0.err  = 1'b0;
        m1.rdat = '0;
        m1.ack  = 1'b0;
        m1.err  = 1'b0;
        grant_o = 2'b00;
        case (r_state)
            ARB_GNT0: begin
                s.cyc   = m0.cyc;
                s.stb   = m0.stb;
                s.we    = m0.we;
                s.sel   = m0.sel;
                s.adr   = m0.adr;
                s.wdat  = m0.wdat;
                m0.rdat = s.rdat;
                m0.ack  = s.ack;
                m0.err  = s.err;
                grant_o = 2'b01;
            end
            ARB_GNT1: begin
                s.cyc   = m1.cyc;
                s.stb   = m1.stb;
                s.we    = m1.we;
                s.sel   = m1.sel;
                s.adr   = m1.adr;
                s.wdat  = m1.wdat;
                m1.rdat = s.rdat;
                m1.ack  = s.ack;
                m1.err  = s.err;
                grant_o = 2'b10;
            end
            ARB_TOUT: begin
                if (r_owner) begin
                    m1.err  = 1'b1;
                    grant_o = 2'b10;
                end else begin
                    m0.err  = 1'b1;
                    grant_o = 2'b01;
                end
            end
            default: begin
                grant_o = 2'b00;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed testbench for wb_arbiter with a short watchdog (TIMEOUT=4).
// Covers single read, hold over multi-beat, slave error, timeout, reset in
// the middle of a cycle and tie-breaking; tie expectations follow
// WB_ARBITER_RR_EN when it is defined.
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    typedef struct {
        logic        m0Cyc;
        logic [31:0] m0Adr;
        logic        m1Cyc;
        logic        m1We;
        logic [31:0] m1Adr;
        logic        sAck;
        logic        sErr;
        logic [31:0] sDat;
        logic [1:0]  eGrant;
        logic        eScyc;
        logic        eSwe;
        logic [31:0] eSadr;
        logic        eM0Ack;
        logic        eM0Err;
        logic [31:0] eM0Dat;
        logic        eM1Ack;
        logic        eM1Err;
        logic [31:0] eM1Dat;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [1:0] grant;
    int         checks;
    int         errors;
    vec_t       vecs[$];

    wb_arbiter_if m0if();
    wb_arbiter_if m1if();
    wb_arbiter_if sif();

    wb_arbiter #(
        .TIMEOUT (4)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst_n),
        .m0      (m0if),
        .m1      (m1if),
        .s       (sif),
        .grant_o (grant)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic idleInputs();
        m0if.cyc = 1'b0; m0if.stb = 1'b0; m0if.we = 1'b0; m0if.sel = '0;
        m0if.adr = '0;   m0if.wdat = '0;
        m1if.cyc = 1'b0; m1if.stb = 1'b0; m1if.we = 1'b0; m1if.sel = '0;
        m1if.adr = '0;   m1if.wdat = '0;
        sif.ack = 1'b0;  sif.err = 1'b0;  sif.rdat = '0;
    endtask

    task automatic applyStimulus(input vec_t v);
        m0if.cyc = v.m0Cyc; m0if.stb = v.m0Cyc; m0if.we = 1'b0; m0if.adr = v.m0Adr;
        m1if.cyc = v.m1Cyc; m1if.stb = v.m1Cyc; m1if.we = v.m1We; m1if.adr = v.m1Adr;
        sif.ack = v.sAck;   sif.err = v.sErr;   sif.rdat = v.sDat;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Both masters request together; checks order, bubble and pass-through.
    task automatic runTie(input logic firstIsM1, input string tag);
        logic [1:0]  gFirst;
        logic [1:0]  gSecond;
        logic [31:0] aFirst;
        logic [31:0] aSecond;
        gFirst  = firstIsM1 ? 2'b10 : 2'b01;
        gSecond = firstIsM1 ? 2'b01 : 2'b10;
        aFirst  = firstIsM1 ? 32'h500 : 32'h400;
        aSecond = firstIsM1 ? 32'h400 : 32'h500;
        m0if.cyc = 1'b1; m0if.stb = 1'b1; m0if.adr = 32'h400; m0if.wdat = 32'hA0A0A0A0; m0if.sel = 3'b011;
        m1if.cyc = 1'b1; m1if.stb = 1'b1; m1if.adr = 32'h500; m1if.wdat = 32'hB1B1B1B1; m1if.sel = 3'b110;
        #2 checkOutput({tag, " idle grant"}, 32'(grant), 32'(2'b00));
        nextCycle();
        sif.ack = 1'b1;
        #2;
        checkOutput({tag, " first grant"}, 32'(grant), 32'(gFirst));
        checkOutput({tag, " first adr"}, sif.adr, aFirst);
        checkOutput({tag, " first wdat"}, sif.wdat, firstIsM1 ? 32'hB1B1B1B1 : 32'hA0A0A0A0);
        checkOutput({tag, " first sel"}, 32'(sif.sel), firstIsM1 ? 32'h6 : 32'h3);
        checkOutput({tag, " first acks"}, {30'd0, m1if.ack, m0if.ack}, 32'(gFirst));
        nextCycle();
        sif.ack = 1'b0;
        if (firstIsM1) begin m1if.cyc = 1'b0; m1if.stb = 1'b0; end
        else begin m0if.cyc = 1'b0; m0if.stb = 1'b0; end
        #2;
        checkOutput({tag, " release grant"}, 32'(grant), 32'(gFirst));
        checkOutput({tag, " release cyc"}, 32'(sif.cyc), 32'h0);
        nextCycle();
        #2;
        checkOutput({tag, " bubble grant"}, 32'(grant), 32'(2'b00));
        checkOutput({tag, " bubble cyc"}, 32'(sif.cyc), 32'h0);
        nextCycle();
        sif.ack = 1'b1;
        #2;
        checkOutput({tag, " second grant"}, 32'(grant), 32'(gSecond));
        checkOutput({tag, " second adr"}, sif.adr, aSecond);
        checkOutput({tag, " second acks"}, {30'd0, m1if.ack, m0if.ack}, 32'(gSecond));
        nextCycle();
        idleInputs();
        nextCycle();
        #2 checkOutput({tag, " end grant"}, 32'(grant), 32'(2'b00));
        nextCycle();
    endtask

    // Main sequence: reset, vector table, then multi-cycle corner cases.
    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        idleInputs();

        //            m0c m0adr   m1c we m1adr   ack err sdat          grant cyc we sadr    a0 e0 d0            a1 e1 d1
        vecs.push_back('{0, 32'h0,   0, 0, 32'h0,   0, 0, 32'h0,        2'b00, 0, 0, 32'h0,   0, 0, 32'h0,        0, 0, 32'h0});
        vecs.push_back('{0, 32'h0,   1, 0, 32'h100, 0, 0, 32'h0,        2'b00, 0, 0, 32'h0,   0, 0, 32'h0,        0, 0, 32'h0});
        vecs.push_back('{0, 32'h0,   1, 0, 32'h100, 0, 0, 32'h0,        2'b10, 1, 0, 32'h100, 0, 0, 32'h0,        0, 0, 32'h0});
        vecs.push_back('{0, 32'h0,   1, 0, 32'h100, 1, 0, 32'hDEADBEEF, 2'b10, 1, 0, 32'h100, 0, 0, 32'h0,        1, 0, 32'hDEADBEEF});
        vecs.push_back('{0, 32'h0,   0, 0, 32'h100, 0, 0, 32'h0,        2'b10, 0, 0, 32'h100, 0, 0, 32'h0,        0, 0, 32'h0});
        vecs.push_back('{0, 32'h0,   0, 0, 32'h0,   0, 0, 32'h0,        2'b00, 0, 0, 32'h0,   0, 0, 32'h0,        0, 0, 32'h0});
        vecs.push_back('{1, 32'h200, 0, 0, 32'h0,   0, 0, 32'h0,        2'b00, 0, 0, 32'h0,   0, 0, 32'h0,        0, 0, 32'h0});
        vecs.push_back('{1, 32'h200, 1, 0, 32'h300, 1, 0, 32'h11111111, 2'b01, 1, 0, 32'h200, 1, 0, 32'h11111111, 0, 0, 32'h0});
        vecs.push_back('{1, 32'h200, 1, 0, 32'h300, 1, 0, 32'h22222222, 2'b01, 1, 0, 32'h200, 1, 0, 32'h22222222, 0, 0, 32'h0});
        vecs.push_back('{1, 32'h200, 1, 0, 32'h300, 1, 0, 32'h33333333, 2'b01, 1, 0, 32'h200, 1, 0, 32'h33333333, 0, 0, 32'h0});
        vecs.push_back('{0, 32'h200, 1, 0, 32'h300, 0, 0, 32'h0,        2'b01, 0, 0, 32'h200, 0, 0, 32'h0,        0, 0, 32'h0});
        vecs.push_back('{0, 32'h0,   1, 1, 32'h300, 0, 0, 32'h0,        2'b00, 0, 0, 32'h0,   0, 0, 32'h0,        0, 0, 32'h0});
        vecs.push_back('{0, 32'h0,   1, 1, 32'h300, 0, 0, 32'h0,        2'b10, 1, 1, 32'h300, 0, 0, 32'h0,        0, 0, 32'h0});
        vecs.push_back('{0, 32'h0,   1, 1, 32'h300, 0, 0, 32'h0,        2'b10, 1, 1, 32'h300, 0, 0, 32'h0,        0, 0, 32'h0});
        vecs.push_back('{0, 32'h0,   1, 1, 32'h300, 0, 1, 32'h0,        2'b10, 1, 1, 32'h300, 0, 0, 32'h0,        0, 1, 32'h0});
        vecs.push_back('{0, 32'h0,   1, 1, 32'h300, 0, 0, 32'h0,        2'b10, 1, 1, 32'h300, 0, 0, 32'h0,        0, 0, 32'h0});
        vecs.push_back('{0, 32'h0,   1, 1, 32'h300, 0, 0, 32'h0,        2'b10, 1, 1, 32'h300, 0, 0, 32'h0,        0, 0, 32'h0});
        vecs.push_back('{0, 32'h0,   1, 1, 32'h300, 0, 0, 32'h0,        2'b10, 1, 1, 32'h300, 0, 0, 32'h0,        0, 0, 32'h0});
        vecs.push_back('{0, 32'h0,   1, 1, 32'h300, 1, 0, 32'hCAFEF00D, 2'b10, 1, 1, 32'h300, 0, 0, 32'h0,        1, 0, 32'hCAFEF00D});
        vecs.push_back('{0, 32'h0,   0, 1, 32'h300, 0, 0, 32'h0,        2'b10, 0, 1, 32'h300, 0, 0, 32'h0,        0, 0, 32'h0});
        vecs.push_back('{0, 32'h0,   0, 0, 32'h0,   0, 0, 32'h0,        2'b00, 0, 0, 32'h0,   0, 0, 32'h0,        0, 0, 32'h0});

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset grant", 32'(grant), 32'h0);
        checkOutput("reset s_cyc", 32'(sif.cyc), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        nextCycle();

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            #2;
            checkOutput($sformatf("v%0d grant", i), 32'(grant), 32'(vecs[i].eGrant));
            checkOutput($sformatf("v%0d s_cyc", i), 32'(sif.cyc), 32'(vecs[i].eScyc));
            checkOutput($sformatf("v%0d s_stb", i), 32'(sif.stb), 32'(vecs[i].eScyc));
            checkOutput($sformatf("v%0d s_we", i), 32'(sif.we), 32'(vecs[i].eSwe));
            checkOutput($sformatf("v%0d s_adr", i), sif.adr, vecs[i].eSadr);
            checkOutput($sformatf("v%0d m0_ack", i), 32'(m0if.ack), 32'(vecs[i].eM0Ack));
            checkOutput($sformatf("v%0d m0_err", i), 32'(m0if.err), 32'(vecs[i].eM0Err));
            checkOutput($sformatf("v%0d m0_dat", i), m0if.rdat, vecs[i].eM0Dat);
            checkOutput($sformatf("v%0d m1_ack", i), 32'(m1if.ack), 32'(vecs[i].eM1Ack));
            checkOutput($sformatf("v%0d m1_err", i), 32'(m1if.err), 32'(vecs[i].eM1Err));
            checkOutput($sformatf("v%0d m1_dat", i), m1if.rdat, vecs[i].eM1Dat);
            nextCycle();
        end
        idleInputs();

        // Timeout: m0 strobes, slave never answers.
        m0if.cyc = 1'b1; m0if.stb = 1'b1; m0if.adr = 32'h700;
        #2 checkOutput("tout idle grant", 32'(grant), 32'h0);
        nextCycle();
        for (int k = 0; k < 4; k++) begin
            #2;
            checkOutput($sformatf("tout wait%0d err", k), 32'(m0if.err), 32'h0);
            checkOutput($sformatf("tout wait%0d s_cyc", k), 32'(sif.cyc), 32'h1);
            checkOutput($sformatf("tout wait%0d grant", k), 32'(grant), 32'h1);
            nextCycle();
        end
        m0if.cyc = 1'b0; m0if.stb = 1'b0;
        #2;
        checkOutput("tout pulse m0_err", 32'(m0if.err), 32'h1);
        checkOutput("tout pulse m1_err", 32'(m1if.err), 32'h0);
        checkOutput("tout pulse s_cyc", 32'(sif.cyc), 32'h0);
        checkOutput("tout pulse s_stb", 32'(sif.stb), 32'h0);
        checkOutput("tout pulse grant", 32'(grant), 32'h1);
        nextCycle();
        #2;
        checkOutput("tout after m0_err", 32'(m0if.err), 32'h0);
        checkOutput("tout after grant", 32'(grant), 32'h0);
        nextCycle();

        // Reset while m1 owns the bus with strobe and ack active.
        m1if.cyc = 1'b1; m1if.stb = 1'b1; m1if.adr = 32'h600;
        nextCycle();
        sif.ack = 1'b1; sif.rdat = 32'h12345678;
        #1 checkOutput("rst pre m1_ack", 32'(m1if.ack), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rst mid grant", 32'(grant), 32'h0);
        checkOutput("rst mid s_cyc", 32'(sif.cyc), 32'h0);
        checkOutput("rst mid s_stb", 32'(sif.stb), 32'h0);
        checkOutput("rst mid s_adr", sif.adr, 32'h0);
        checkOutput("rst mid m1_ack", 32'(m1if.ack), 32'h0);
        checkOutput("rst mid m1_dat", m1if.rdat, 32'h0);
        idleInputs();
        nextCycle();
        @(negedge clk);
        rst_n = 1'b1;
        nextCycle();
        m1if.cyc = 1'b1; m1if.stb = 1'b1; m1if.adr = 32'h640;
        #2 checkOutput("rst fresh idle", 32'(grant), 32'h0);
        nextCycle();
        sif.ack = 1'b1;
        #2;
        checkOutput("rst fresh grant", 32'(grant), 32'h2);
        checkOutput("rst fresh m1_ack", 32'(m1if.ack), 32'h1);
        nextCycle();
        idleInputs();
        nextCycle();

`ifdef WB_ARBITER_RR_EN
        runTie(1'b0, "tie1");
`else
        runTie(1'b1, "tie1");
`endif
        // Solo m0 transaction so m0 is the most recent owner before tie 2.
        m0if.cyc = 1'b1; m0if.stb = 1'b1; m0if.adr = 32'h800;
        nextCycle();
        sif.ack = 1'b1;
        #2 checkOutput("solo m0 grant", 32'(grant), 32'h1);
        nextCycle();
        idleInputs();
        nextCycle();
        runTie(1'b1, "tie2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
